// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: widths, funct3
// encodings, FSM states and operand-signedness helpers.
package muldiv_unit_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGISTER   = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGISTER);
  localparam int ACC_WIDTH      = 2 * DATA_WIDTH;
  localparam int CNT_WIDTH      = $clog2(DATA_WIDTH);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Turns unsigned magnitude results back into the signed RV32M result and
// selects the word funct3 asks for; divide-by-zero overrides the quotient.
module muldiv_signfix
  import muldiv_unit_pkg::*;
(
  input  logic [2:0]            i_funct3,
  input  logic [ACC_WIDTH-1:0]  i_acc,
  input  logic                  i_neg_a,
  input  logic                  i_neg_b,
  input  logic                  i_div_zero,
  output logic [DATA_WIDTH-1:0] o_result
);

  logic [ACC_WIDTH-1:0]  prod;
  logic [DATA_WIDTH-1:0] quot;
  logic [DATA_WIDTH-1:0] rem;

  // For divides the accumulator holds {remainder, quotient}.
  always_comb begin
    prod = (i_neg_a ^ i_neg_b) ? -i_acc : i_acc;
    quot = (i_neg_a ^ i_neg_b) ? -i_acc[DATA_WIDTH-1:0] : i_acc[DATA_WIDTH-1:0];
    if (i_div_zero) quot = '1;
    rem  = i_neg_a ? -i_acc[ACC_WIDTH-1:DATA_WIDTH] : i_acc[ACC_WIDTH-1:DATA_WIDTH];
  end

  always_comb begin
    o_result = '0;
    case (i_funct3)
      F3_MUL:                        o_result = prod[DATA_WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  o_result = prod[ACC_WIDTH-1:DATA_WIDTH];
      F3_DIV, F3_DIVU:               o_result = quot;
      F3_REM, F3_REMU:               o_result = rem;
      default:                       o_result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over 32 cycles,
// with a fast path for divide-by-zero and signed overflow.
//
//   state | meaning
//   IDLE  | ready for issue
//   CALC  | 32 shift-add / shift-subtract iterations
//   DONE  | one-cycle write-back pulse
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic [2:0]                i_funct3,
  input  logic [DATA_WIDTH-1:0]     i_rs1,
  input  logic [DATA_WIDTH-1:0]     i_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                      i_flush,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
  output logic [DATA_WIDTH-1:0]     o_result
);

  state_t                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic [DATA_WIDTH-1:0]     b_q, b_d;
  logic                      neg_a_q, neg_a_d;
  logic                      neg_b_q, neg_b_d;
  logic                      div_zero_q, div_zero_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] rd_out_q, rd_out_d;

  logic                      accept;
  logic                      in_neg_a, in_neg_b;
  logic [DATA_WIDTH-1:0]     in_a_mag, in_b_mag;
  logic                      in_div_zero, in_ovf, in_special;
  logic [DATA_WIDTH:0]       mul_sum, div_trial, div_diff;
  logic [DATA_WIDTH-1:0]     fix_result;

  assign accept      = (state_q == ST_IDLE) && i_valid && !i_flush;
  assign in_neg_a    = rs1_is_signed(i_funct3) && i_rs1[DATA_WIDTH-1];
  assign in_neg_b    = rs2_is_signed(i_funct3) && i_rs2[DATA_WIDTH-1];
  assign in_a_mag    = in_neg_a ? -i_rs1 : i_rs1;
  assign in_b_mag    = in_neg_b ? -i_rs2 : i_rs2;
  assign in_div_zero = i_funct3[2] && (i_rs2 == '0);
  assign in_ovf      = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                       (i_rs1 == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (i_rs2 == '1);
  assign in_special  = in_div_zero || in_ovf;

  assign mul_sum   = {1'b0, acc_q[ACC_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_trial = acc_q[ACC_WIDTH-1:DATA_WIDTH-1];
  assign div_diff  = div_trial - {1'b0, b_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = in_special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (i_flush)            state_d = ST_IDLE;
        else if (cnt_q == '1)   state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == ST_IDLE);
    o_valid = (state_q == ST_DONE) && !i_flush;
  end

  always_comb begin
    cnt_d      = cnt_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    acc_d      = acc_q;
    b_d        = b_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        funct3_d   = i_funct3;
        rd_d       = i_rd_addr;
        neg_a_d    = in_neg_a;
        neg_b_d    = in_neg_b;
        div_zero_d = in_div_zero;
        b_d        = in_b_mag;
        cnt_d      = '0;
        // Divide-by-zero parks the dividend in the remainder half so REM returns rs1.
        acc_d      = in_div_zero ? {in_a_mag, {DATA_WIDTH{1'b0}}}
                                 : {{DATA_WIDTH{1'b0}}, in_a_mag};
      end
      ST_CALC: if (!i_flush) begin
        cnt_d = cnt_q + 1'b1;
        if (funct3_q[2]) begin
          if (!div_diff[DATA_WIDTH])
            acc_d = {div_diff[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
          else
            acc_d = {div_trial[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[DATA_WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

  muldiv_signfix u_signfix (
    .i_funct3   (funct3_d),
    .i_acc      (acc_d),
    .i_neg_a    (neg_a_d),
    .i_neg_b    (neg_b_d),
    .i_div_zero (div_zero_d),
    .o_result   (fix_result)
  );

  // Output word is captured on the way into DONE and held afterwards.
  always_comb begin
    result_d = result_q;
    rd_out_d = rd_out_q;
    if (state_d == ST_DONE) begin
      result_d = fix_result;
      rd_out_d = rd_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
      rd_out_q   <= rd_out_d;
    end
  end

  assign o_result  = result_q;
  assign o_rd_addr = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops
// against an arithmetic reference model, and flush/reset/hold sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        o_ready, o_valid;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .i_funct3  (funct3),
    .i_rs1     (rs1),
    .i_rs2     (rs2),
    .i_rd_addr (rd_addr),
    .i_flush   (flush),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_rd_addr (o_rd_addr),
    .o_result  (o_result)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin sp = sa * sb; p = sp; return p[63:32]; end
      3'd2: begin sp = sa * longint'(ub); p = sp; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; p = sp; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; sp = sa % sb; p = sp; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at posedge+1 with the unit idle; the next edge is the accept edge (cycle 0).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold,
                        output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int pulses, output int busy_bad);
    res = '0; rdo = '0; lat = -1; pulses = 0; busy_bad = 0;
    funct3 = f3; rs1 = a; rs2 = b; rd_addr = rd; valid = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!hold || n >= 34) valid = 1'b0;
      @(negedge clk);
      if (o_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n; res = o_result; rdo = o_rd_addr;
        end
      end
      if ((lat < 0 || lat == n) && o_ready) busy_bad++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input bit hold,
                               input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    logic [4:0]  rdo;
    int lat, pulses, busy_bad;
    run_op(f3, a, b, rd, hold, res, rdo, lat, pulses, busy_bad);
    check({tag, " result"}, res, exp_res);
    check({tag, " rd_addr"}, {27'h0, rdo}, {27'h0, rd});
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " ready_low_while_busy"}, 32'(busy_bad), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          pulses;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        33});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         33});
    vecs.push_back('{3'd4, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'd5,          32'd0,         5'd11, 32'd5,         1});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         1});
    vecs.push_back('{3'd5, 32'd9,          32'd0,         5'd0,  32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd7, 32'hFFFF_FFF0,  32'd0,         5'd31, 32'hFFFF_FFF0, 1});

    rst_n = 1'b0; valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_addr = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready", {31'h0, o_ready}, 32'd1);
    check("reset valid", {31'h0, o_valid}, 32'd0);
    check("reset result", o_result, 32'd0);
    check("reset rd_addr", {27'h0, o_rd_addr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0,
                    vecs[i].exp_res, vecs[i].exp_lat);

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      rd = 5'($urandom_range(0, 31));
      run_and_check($sformatf("rand%0d", i), f3, a, b, rd, 1'b0, model(f3, a, b), model_lat(f3, a, b));
    end

    // Flush while idle must block acceptance.
    funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_addr = 5'd1; valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush ready", {31'h0, o_ready}, 32'd1);
    @(posedge clk); #1;

    // Flush during a DIVU in cycle 10.
    pulses = 0;
    funct3 = 3'd5; rs1 = 32'hDEAD_BEEF; rs2 = 32'd3; rd_addr = 5'd9; valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      if (n == 10) flush = 1'b1;
      @(negedge clk);
      if (o_valid) pulses++;
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush ready_cycle11", {31'h0, o_ready}, 32'd1);
    if (o_valid) pulses++;
    check("flush no_valid", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    run_and_check("post_flush_mul", 3'd0, 32'd3, 32'd4, 5'd9, 1'b0, 32'd12, 33);

    // Held i_valid while busy: exactly one pulse.
    run_and_check("hold_valid", 3'd0, 32'h0001_0003, 32'h0000_0101, 5'd17, 1'b1,
                  model(3'd0, 32'h0001_0003, 32'h0000_0101), 33);

    // Asynchronous reset in cycle 20 of a MUL.
    funct3 = 3'd0; rs1 = 32'h1234; rs2 = 32'h5678; rd_addr = 5'd3; valid = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst ready", {31'h0, o_ready}, 32'd1);
    check("async_rst valid", {31'h0, o_valid}, 32'd0);
    check("async_rst result", o_result, 32'd0);
    check("async_rst rd_addr", {27'h0, o_rd_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    check("after_rst no_valid", 32'(pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
